// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
// Early termination is enabled by defining SEQ_MULT_EARLY_TERM_EN.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiply-add: product = A*B + C, one bit of B per edge.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining B is zero.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic [N-1:0]   addend,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = cnt_width(N);

  state_e         state_q;
  logic [2*N-1:0] a_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [N-1:0]   b_q;
  logic [N-1:0]   b_d;
  logic [CW-1:0]  cnt_q;
  logic           last_d;

  always_comb begin
    acc_d  = b_q[0] ? acc_q + a_q : acc_q;
    b_d    = b_q >> 1;
    last_d = (cnt_q == CW'(N - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
    // Nothing left to add once the shifted-out multiplier is empty.
    if (b_d == '0) last_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            a_q     <= {{N{1'b0}}, multiplicand};
            b_q     <= multiplier;
            acc_q   <= {{N{1'b0}}, addend};
            cnt_q   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_d) begin
            state_q <= DONE;
            product <= acc_d;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed checks of seq_multiplier against A*B+C.
// Expected latency follows SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   c;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .addend       (c),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int bv);
    int l;
    l = N;
`ifdef SEQ_MULT_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < N; i++)
      if (((bv >> i) & 1) == 1) l = i + 1;
`endif
    return l;
  endfunction

  task automatic launch(input int av, input int bv, input int cv);
    @(negedge clk);
    a     = N'(av);
    b     = N'(bv);
    c     = N'(cv);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic op(input string tag, input int av, input int bv,
                    input int cv, input bit full);
    int lat;
    launch(av, bv, cv);
    if (full) begin
      chk({tag, "_busy_run"}, busy, 1);
      chk({tag, "_done_run"}, done, 0);
    end
    wait_done(lat);
    if (full) begin
      chk({tag, "_lat"}, lat, exp_lat(bv));
      chk({tag, "_busy_end"}, busy, 0);
    end
    chk({tag, "_prod"}, product, av * bv + cv);
  endtask

  initial begin
    int lat;
    int more;
    int av, bv, cv;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c     = '0;
    #1;
    chk("rst_prod", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    op("d_15x7", 15, 7, 0, 1'b1);
    chk("d_15x7_done", done, 1);
    op("d_max", 15, 15, 15, 1'b1);
    op("d_zero_a", 0, 9, 6, 1'b1);
    op("d_b1", 9, 1, 0, 1'b1);
    op("d_b0", 5, 0, 4, 1'b1);
    op("d_b8", 3, 8, 2, 1'b1);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("hold_done", done, 1);
    chk("hold_prod", product, 3 * 8 + 2);

    // Restart request in the middle of RUN must be ignored.
    launch(15, 13, 2);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    a     = 4'd1;
    b     = 4'd1;
    c     = 4'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(more);
    chk("restart_lat", 3 + more, exp_lat(13));
    chk("restart_prod", product, 15 * 13 + 2);

    // Asynchronous reset in the middle of RUN.
    launch(15, 15, 15);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_prod", product, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    op("post_rst", 3, 5, 1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      av = int'($urandom_range(0, 15));
      bv = int'($urandom_range(0, 15));
      cv = int'($urandom_range(0, 15));
      op("rand", av, bv, cv, 1'b1);
    end

    // Divider round-trip: quotient*divisor + remainder == dividend.
    for (int j = 0; j < 16; j++) begin
      for (int i = 1; i < 16; i++) begin
        launch(j / i, i, j % i);
        wait_done(lat);
        chk("divrt", product, j);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
